// File: rtl/max7219_pkg.sv
// Shared constants, FSM state type and frame helpers for the MAX7219 digit serializer.
package max7219_pkg;

    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    localparam logic [7:0] BLANK_CODE = 8'h0F;
    localparam int         N_INIT     = 6;

    typedef enum logic [2:0] {
        INIT_LOAD = 3'd0,
        RUN_IDLE  = 3'd1,
        SHIFT_LO  = 3'd2,
        SHIFT_HI  = 3'd3,
        GAP       = 3'd4
    } state_e;

    function automatic logic [15:0] make_frame(input logic [3:0] addr, input logic [7:0] data);
        return {4'h0, addr, data};
    endfunction

    // Power-up register sequence: shut down, leave test mode, configure, then wake.
    function automatic logic [15:0] init_word(input logic [2:0] idx,
                                              input logic [3:0] intensity,
                                              input logic [2:0] scan_limit);
        logic [15:0] w;
        case (idx)
            3'd0:    w = make_frame(ADDR_SHUTDOWN, 8'h00);
            3'd1:    w = make_frame(ADDR_TEST, 8'h00);
            3'd2:    w = make_frame(ADDR_DECODE, 8'h01);
            3'd3:    w = make_frame(ADDR_SCANLIM, {5'b00000, scan_limit});
            3'd4:    w = make_frame(ADDR_INTENSITY, {4'h0, intensity});
            default: w = make_frame(ADDR_SHUTDOWN, 8'h01);
        endcase
        return w;
    endfunction

endpackage

// File: rtl/max7219_digit_serializer_if.sv
// Digit/enable inputs and the 3-wire MAX7219 link plus busy status.
interface max7219_digit_serializer_if;
    logic [3:0] digit;
    logic       display_active;
    logic       DIN;
    logic       CS;
    logic       SCLK;
    logic       busy;

    modport master (input digit, input display_active,
                    output DIN, output CS, output SCLK, output busy);
    modport slave  (output digit, output display_active,
                    input DIN, input CS, input SCLK, input busy);
endinterface

// File: rtl/max7219_digit_serializer_spi16_tx.sv
// 16-bit MSB-first frame transmitter: SCLK divider, CS framing and inter-frame gap.
module spi16_tx
    import max7219_pkg::*;
#(
    parameter int CLK_DIV = 1,
    parameter int CS_GAP  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [15:0] data_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        din_o,
    output logic        cs_o,
    output logic        sclk_o
);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int GW = $clog2(CS_GAP + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

    state_e        state_q;
    logic [DW-1:0] div_q;
    logic [GW-1:0] gap_q;
    logic [3:0]    bit_q;
    logic [14:0]   shreg_q;
    logic          cs_q;
    logic          sclk_q;
    logic          din_q;
    logic          busy_q;

    // The last gap cycle doubles as idle so frames can run back-to-back.
    assign ready_o = (state_q == RUN_IDLE) || ((state_q == GAP) && (gap_q == GAP_LAST));
    assign busy_o  = busy_q;
    assign din_o   = din_q;
    assign cs_o    = cs_q;
    assign sclk_o  = sclk_q;

    // Frame sequencing: load, low/high SCLK phases per bit, then CS-high gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN_IDLE;
            div_q   <= '0;
            gap_q   <= '0;
            bit_q   <= 4'd0;
            shreg_q <= 15'd0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            din_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else if (start_i && ready_o) begin
            state_q <= SHIFT_LO;
            div_q   <= '0;
            gap_q   <= '0;
            bit_q   <= 4'd15;
            shreg_q <= data_i[14:0];
            cs_q    <= 1'b0;
            sclk_q  <= 1'b0;
            din_q   <= data_i[15];
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                SHIFT_LO: begin
                    if (div_q == DIV_LAST) begin
                        div_q   <= '0;
                        sclk_q  <= 1'b1;
                        state_q <= SHIFT_HI;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                SHIFT_HI: begin
                    if (div_q == DIV_LAST) begin
                        div_q  <= '0;
                        sclk_q <= 1'b0;
                        if (bit_q == 4'd0) begin
                            cs_q    <= 1'b1;
                            din_q   <= 1'b0;
                            gap_q   <= '0;
                            state_q <= GAP;
                        end else begin
                            bit_q   <= bit_q - 4'd1;
                            din_q   <= shreg_q[14];
                            shreg_q <= {shreg_q[13:0], 1'b0};
                            state_q <= SHIFT_LO;
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= RUN_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                RUN_IDLE: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= RUN_IDLE;
                    cs_q    <= 1'b1;
                    sclk_q  <= 1'b0;
                    din_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/max7219_digit_serializer.sv
// MAX7219 driver: power-up init sequence, then digit-register writes on value change.
module max7219_digit_serializer
    import max7219_pkg::*;
#(
    parameter int         CLK_DIV    = 1,
    parameter int         CS_GAP     = 2,
    parameter logic [3:0] INTENSITY  = 4'h8,
    parameter logic [2:0] SCAN_LIMIT = 3'd0
) (
    input logic                         clk,
    input logic                         rst_n,
    max7219_digit_serializer_if.master  bus
);
    localparam logic [2:0] INIT_LAST = 3'(N_INIT - 1);

    state_e      phase_q, phase_d;
    logic [2:0]  init_idx_q, init_idx_d;
    logic [7:0]  last_sent_q, last_sent_d;
    logic        sent_valid_q, sent_valid_d;

    logic [7:0]  data_byte_s;
    logic        tx_start_s;
    logic [15:0] tx_frame_s;
    logic        tx_ready_s;

    // Pick the next frame: init ROM first, then a digit write only when D changed.
    always_comb begin
        data_byte_s  = (bus.display_active && (bus.digit <= 4'd9)) ? {4'h0, bus.digit} : BLANK_CODE;
        phase_d      = phase_q;
        init_idx_d   = init_idx_q;
        last_sent_d  = last_sent_q;
        sent_valid_d = sent_valid_q;
        tx_start_s   = 1'b0;
        tx_frame_s   = 16'h0000;
        if (phase_q == INIT_LOAD) begin
            tx_start_s = tx_ready_s;
            tx_frame_s = init_word(init_idx_q, INTENSITY, SCAN_LIMIT);
            if (tx_ready_s) begin
                init_idx_d = init_idx_q + 3'd1;
                phase_d    = (init_idx_q == INIT_LAST) ? RUN_IDLE : INIT_LOAD;
            end else begin
                init_idx_d = init_idx_q;
            end
        end else begin
            tx_start_s = tx_ready_s && (!sent_valid_q || (data_byte_s != last_sent_q));
            tx_frame_s = make_frame(ADDR_DIGIT0, data_byte_s);
            if (tx_start_s) begin
                last_sent_d  = data_byte_s;
                sent_valid_d = 1'b1;
            end else begin
                last_sent_d  = last_sent_q;
                sent_valid_d = sent_valid_q;
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= INIT_LOAD;
            init_idx_q   <= 3'd0;
            last_sent_q  <= 8'h00;
            sent_valid_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            init_idx_q   <= init_idx_d;
            last_sent_q  <= last_sent_d;
            sent_valid_q <= sent_valid_d;
        end
    end

    spi16_tx #(
        .CLK_DIV (CLK_DIV),
        .CS_GAP  (CS_GAP)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (tx_start_s),
        .data_i  (tx_frame_s),
        .ready_o (tx_ready_s),
        .busy_o  (bus.busy),
        .din_o   (bus.DIN),
        .cs_o    (bus.CS),
        .sclk_o  (bus.SCLK)
    );

endmodule
